// File: rtl/img_blur_pkg.sv
// ---------------------------------------------------------------------------
// img_blur_pkg
// Shared constants, kernel weights, read FSM state type and helper functions
// for the streaming 3x3 blur engine.
//
// Build option:
//   KERNEL_GAUSSIAN_EN  defined   -> weights [1 2 1; 2 4 2; 1 2 1], result = sum >> 4
//   KERNEL_GAUSSIAN_EN  undefined -> uniform box weights, result = floor(sum / 9)
// ---------------------------------------------------------------------------
package img_blur_pkg;

    localparam int IMG_W          = 512;
    localparam int PIX_W          = 8;
    localparam int NUM_LB         = 4;
    localparam int OFIFO_D        = 32;

    localparam int COL_W          = $clog2(IMG_W);
    localparam int LB_W           = $clog2(NUM_LB);
    localparam int FILL_W         = $clog2(NUM_LB + 1);
    localparam int FIFO_AW        = $clog2(OFIFO_D);
    localparam int SUM_W          = 12;
    localparam int ROWS_PER_WIN   = 3;
    localparam int ISSUE_MIN_FREE = 4;

    // Kernel weights, row-major: index = row * 3 + column.
`ifdef KERNEL_GAUSSIAN_EN
    localparam logic [2:0] KERNEL_W [9] = '{3'd1, 3'd2, 3'd1,
                                            3'd2, 3'd4, 3'd2,
                                            3'd1, 3'd2, 3'd1};
`else
    localparam logic [2:0] KERNEL_W [9] = '{3'd1, 3'd1, 3'd1,
                                            3'd1, 3'd1, 3'd1,
                                            3'd1, 3'd1, 3'd1};
    // ceil(2^16 / 9); exact floor(sum/9) for every sum below 32768.
    localparam logic [12:0] DIV9_MUL = 13'd7282;
`endif

    typedef enum logic {
        RD_IDLE,
        RD_READ
    } rdState_t;

    // Ring index arithmetic: (base + step) mod NUM_LB.
    function automatic logic [LB_W-1:0] lbOffset(input logic [LB_W-1:0] base,
                                                 input int unsigned step);
        int unsigned idx;
        idx = (32'(base) + step) % NUM_LB;
        return LB_W'(idx);
    endfunction

    // Turns the weighted window sum into the output pixel.
    function automatic logic [PIX_W-1:0] kernelNormalize(input logic [SUM_W-1:0] sum);
`ifdef KERNEL_GAUSSIAN_EN
        return PIX_W'(sum >> 4);
`else
        logic [23:0] prod;
        prod = 24'(sum) * 24'(DIV9_MUL);
        return PIX_W'(prod >> 16);
`endif
    endfunction

endpackage

// File: rtl/line_buffer.sv
// ---------------------------------------------------------------------------
// line_buffer
// One image row (IMG_W x PIX_W). Single write port; the read side returns
// the three consecutive pixels at rdPtr, rdPtr+1, rdPtr+2, with any column
// beyond IMG_W-1 returned as zero (right-edge padding).
//
// Ports:
//   clk     in   clock, rising edge
//   wrEn    in   write strobe
//   wrPtr   in   write column
//   wrData  in   pixel to write
//   rdPtr   in   first read column
//   rdData  out  {pix[rdPtr+2], pix[rdPtr+1], pix[rdPtr]}
// ---------------------------------------------------------------------------
module line_buffer
    import img_blur_pkg::*;
(
    input  logic                 clk,
    input  logic                 wrEn,
    input  logic [COL_W-1:0]     wrPtr,
    input  logic [PIX_W-1:0]     wrData,
    input  logic [COL_W-1:0]     rdPtr,
    output logic [3*PIX_W-1:0]   rdData
);

    logic [PIX_W-1:0] mem [IMG_W];

    // Row storage; contents are meaningless until written, so no reset.
    always_ff @(posedge clk) begin
        if (wrEn) begin
            mem[wrPtr] <= wrData;
        end
    end

    // Three-tap read; taps past the row end are forced to zero.
    always_comb begin
        rdData = '0;
        for (int k = 0; k < 3; k++) begin
            if (((COL_W+1)'(rdPtr) + (COL_W+1)'(k)) < (COL_W+1)'(IMG_W)) begin
                rdData[k*PIX_W +: PIX_W] = mem[rdPtr + COL_W'(k)];
            end
        end
    end

endmodule

// File: rtl/img_blur_top.sv
// ---------------------------------------------------------------------------
// img_blur_top
// Streaming 3x3 blur for 8-bit grayscale rows of IMG_W pixels. Input rows go
// into a ring of NUM_LB line buffers; once three rows are held, one output
// row is produced from that row-triple, then the oldest buffer is released
// and o_intr pulses so the host can send another row.
//
// Pipeline: window issue (address) -> registered window -> registered sum ->
// registered quotient (output FIFO entry); 3 cycles from issue to FIFO.
//
// Ports:
//   clk           in   clock, rising edge
//   rst           in   asynchronous reset, active low
//   i_valid       in   input pixel valid
//   i_data        in   input pixel, raster order
//   o_data_ready  out  input pixel can be accepted
//   o_data_valid  out  output FIFO not empty
//   o_data        out  output FIFO head (0 when empty)
//   i_data_ready  in   sink takes the output pixel
//   o_intr        out  one-cycle pulse per released line buffer
//
// Build option: KERNEL_GAUSSIAN_EN selects the Gaussian kernel (see package).
// ---------------------------------------------------------------------------
module img_blur_top
    import img_blur_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             i_valid,
    input  logic [PIX_W-1:0] i_data,
    output logic             o_data_ready,
    output logic             o_data_valid,
    output logic [PIX_W-1:0] o_data,
    input  logic             i_data_ready,
    output logic             o_intr
);

    logic [COL_W-1:0]    wrPtr;
    logic [LB_W-1:0]     wrBuf;
    logic [FILL_W-1:0]   linesFull;
    logic                wrAccept;
    logic                rowWriteDone;

    rdState_t            state;
    rdState_t            stateNext;
    logic [COL_W-1:0]    colPtr;
    logic [LB_W-1:0]     rdBase;
    logic                issue;
    logic                lastIssue;

    logic [3*PIX_W-1:0]  lbRdData [NUM_LB];

    logic [PIX_W-1:0]    win [3][3];
    logic                winValid;
    logic [SUM_W-1:0]    sumNext;
    logic [SUM_W-1:0]    sumReg;
    logic                sumValid;

    logic [PIX_W-1:0]    fifoMem [OFIFO_D];
    logic [FIFO_AW-1:0]  fifoWrPtr;
    logic [FIFO_AW-1:0]  fifoRdPtr;
    logic [FIFO_AW:0]    fifoCount;
    logic                fifoPush;
    logic                fifoPop;
    logic                fifoRoom;

    assign o_data_ready = (linesFull < FILL_W'(NUM_LB));
    assign wrAccept     = i_valid && o_data_ready;
    assign rowWriteDone = wrAccept && (wrPtr == COL_W'(IMG_W - 1));

    // Write side: fill the current buffer column by column, then move on.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wrPtr <= '0;
            wrBuf <= '0;
        end else if (wrAccept) begin
            if (rowWriteDone) begin
                wrPtr <= '0;
                wrBuf <= lbOffset(wrBuf, 1);
            end else begin
                wrPtr <= wrPtr + 1'b1;
            end
        end
    end

    // Number of complete rows held; a write and a release in the same cycle cancel.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            linesFull <= '0;
        end else if (rowWriteDone && !lastIssue) begin
            linesFull <= linesFull + 1'b1;
        end else if (lastIssue && !rowWriteDone) begin
            linesFull <= linesFull - 1'b1;
        end
    end

    for (genvar i = 0; i < NUM_LB; i++) begin : gLineBuf
        line_buffer uLineBuf (
            .clk    (clk),
            .wrEn   (wrAccept && (wrBuf == LB_W'(i))),
            .wrPtr  (wrPtr),
            .wrData (i_data),
            .rdPtr  (colPtr),
            .rdData (lbRdData[i])
        );
    end

    // Counting only landed entries is enough: with at most three windows in
    // flight, a threshold of four free slots can never overflow the FIFO.
    assign fifoRoom = ((FIFO_AW+1)'(OFIFO_D) - fifoCount) >= (FIFO_AW+1)'(ISSUE_MIN_FREE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= RD_IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext = state;
        issue     = 1'b0;
        lastIssue = 1'b0;
        case (state)
            RD_IDLE: begin
                if ((linesFull >= FILL_W'(ROWS_PER_WIN)) && fifoRoom) begin
                    stateNext = RD_READ;
                end
            end
            RD_READ: begin
                if (fifoRoom) begin
                    issue = 1'b1;
                    if (colPtr == COL_W'(IMG_W - 1)) begin
                        lastIssue = 1'b1;
                        stateNext = RD_IDLE;
                    end
                end
            end
            default: stateNext = RD_IDLE;
        endcase
    end

    // Column walk across the row-triple; the ring base moves on the last window.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            colPtr <= '0;
            rdBase <= '0;
            o_intr <= 1'b0;
        end else begin
            o_intr <= lastIssue;
            if (issue) begin
                if (lastIssue) begin
                    colPtr <= '0;
                    rdBase <= lbOffset(rdBase, 1);
                end else begin
                    colPtr <= colPtr + 1'b1;
                end
            end
        end
    end

    // Window register: rows are picked relative to the ring base at issue time,
    // so a base advance on the last window cannot disturb that window.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            winValid <= 1'b0;
            for (int r = 0; r < 3; r++) begin
                for (int k = 0; k < 3; k++) begin
                    win[r][k] <= '0;
                end
            end
        end else begin
            winValid <= issue;
            if (issue) begin
                for (int r = 0; r < 3; r++) begin
                    for (int k = 0; k < 3; k++) begin
                        win[r][k] <= lbRdData[lbOffset(rdBase, r)][k*PIX_W +: PIX_W];
                    end
                end
            end
        end
    end

    always_comb begin
        sumNext = '0;
        for (int r = 0; r < 3; r++) begin
            for (int k = 0; k < 3; k++) begin
                sumNext = sumNext + SUM_W'(win[r][k]) * SUM_W'(KERNEL_W[r*3 + k]);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sumValid <= 1'b0;
            sumReg   <= '0;
        end else begin
            sumValid <= winValid;
            if (winValid) begin
                sumReg <= sumNext;
            end
        end
    end

    assign fifoPush     = sumValid;
    assign o_data_valid = (fifoCount != '0);
    assign fifoPop      = o_data_valid && i_data_ready;
    assign o_data       = o_data_valid ? fifoMem[fifoRdPtr] : '0;

    // The FIFO slot itself is the quotient register of the pipeline.
    always_ff @(posedge clk) begin
        if (fifoPush) begin
            fifoMem[fifoWrPtr] <= kernelNormalize(sumReg);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fifoWrPtr <= '0;
            fifoRdPtr <= '0;
            fifoCount <= '0;
        end else begin
            if (fifoPush) begin
                fifoWrPtr <= fifoWrPtr + 1'b1;
            end
            if (fifoPop) begin
                fifoRdPtr <= fifoRdPtr + 1'b1;
            end
            case ({fifoPush, fifoPop})
                2'b10:   fifoCount <= fifoCount + 1'b1;
                2'b01:   fifoCount <= fifoCount - 1'b1;
                default: fifoCount <= fifoCount;
            endcase
        end
    end

endmodule

// File: tb/tb_img_blur_top.sv
// ---------------------------------------------------------------------------
// tb_img_blur_top
// Self-checking bench for img_blur_top. Frames are short (a few rows of 512
// pixels plus the two zero rows) and every output pixel is compared with a
// direct 3x3 sum over the frame array.
// ---------------------------------------------------------------------------
module tb_img_blur_top;

    localparam int W        = 512;
    localparam int MAX_ROWS = 6;

    logic       clk = 1'b0;
    logic       rst;
    logic       i_valid;
    logic [7:0] i_data;
    logic       o_data_ready;
    logic       o_data_valid;
    logic [7:0] o_data;
    logic       i_data_ready;
    logic       o_intr;

    int         errorCount = 0;
    int         checkCount = 0;
    int         frame [MAX_ROWS*W];
    logic [7:0] got [$];
    int         intrCount;

    img_blur_top dut (
        .clk          (clk),
        .rst          (rst),
        .i_valid      (i_valid),
        .i_data       (i_data),
        .o_data_ready (o_data_ready),
        .o_data_valid (o_data_valid),
        .o_data       (o_data),
        .i_data_ready (i_data_ready),
        .o_intr       (o_intr)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    // kind 0 = random, 1 = constant value, 2 = ramp (pixel = column mod 256).
    task automatic fillFrame(input int kind, input int nIn, input int value);
        for (int r = 0; r < MAX_ROWS; r++) begin
            for (int c = 0; c < W; c++) begin
                if (r >= nIn)       frame[r*W + c] = 0;
                else if (kind == 0) frame[r*W + c] = int'($urandom_range(0, 255));
                else if (kind == 1) frame[r*W + c] = value;
                else                frame[r*W + c] = c % 256;
            end
        end
    endtask

    // Output pixel (r, c) from rows r..r+2 and columns c..c+2, zero past the row end.
    function automatic int modelPixel(input int r, input int c);
        int sum = 0;
        for (int dr = 0; dr < 3; dr++) begin
            for (int dc = 0; dc < 3; dc++) begin
                if (c + dc < W) begin
`ifdef KERNEL_GAUSSIAN_EN
                    sum += frame[(r+dr)*W + c + dc] * ((dr == 1) ? 2 : 1) * ((dc == 1) ? 2 : 1);
`else
                    sum += frame[(r+dr)*W + c + dc];
`endif
                end
            end
        end
`ifdef KERNEL_GAUSSIAN_EN
        return sum / 16;
`else
        return sum / 9;
`endif
    endfunction

    function automatic logic [7:0] gotAt(input int idx);
        if (idx < got.size()) return got[idx];
        return 8'bx;
    endfunction

    task automatic doReset();
        rst          = 1'b0;
        i_valid      = 1'b1;
        i_data       = 8'hA5;
        i_data_ready = 1'b1;
        repeat (4) begin
            @(negedge clk);
            checkOutput("reset o_data_valid", 32'(o_data_valid), 0);
            checkOutput("reset o_intr",       32'(o_intr),       0);
            checkOutput("reset o_data_ready", 32'(o_data_ready), 1);
            checkOutput("reset o_data",       32'(o_data),       0);
        end
        @(posedge clk);
        #1;
        rst     = 1'b1;
        i_valid = 1'b0;
    endtask

    // Streams nIn rows plus two zero rows and collects nIn*W outputs.
    // readyMode: 0 always ready, 1 toggle, 2 random, 3 stalled until four rows are in.
    task automatic applyStimulus(input int nIn, input int readyMode, input bit validRandom);
        int totalPix = (nIn + 2) * W;
        int wantOut  = nIn * W;
        int budget   = 4 * totalPix + 4000;
        int pIdx     = 0;
        int cycles   = 0;
        int fullCycles = 0;
        bit sawReadyInFull = 1'b0;
        got.delete();
        intrCount = 0;
        while ((got.size() < wantOut) && (cycles < budget)) begin
            @(posedge clk);
            #1;
            if (pIdx < totalPix) begin
                i_valid = validRandom ? ($urandom_range(0, 3) != 0) : 1'b1;
                i_data  = 8'(frame[pIdx]);
            end else begin
                i_valid = 1'b0;
                i_data  = 8'h00;
            end
            case (readyMode)
                0:       i_data_ready = 1'b1;
                1:       i_data_ready = (cycles % 2 == 0);
                2:       i_data_ready = ($urandom_range(0, 1) == 1);
                default: i_data_ready = (pIdx >= 4*W);
            endcase
            @(negedge clk);
            if (o_intr) intrCount++;
            if ((readyMode == 3) && (pIdx >= 4*W) && (intrCount == 0)) begin
                fullCycles++;
                if (o_data_ready) sawReadyInFull = 1'b1;
            end
            if (i_valid && o_data_ready) pIdx++;
            if (o_data_valid && i_data_ready) got.push_back(o_data);
            cycles++;
        end
        i_valid = 1'b0;
        checkOutput("output count", 32'(got.size()), 32'(wantOut));
        checkOutput("intr count",   32'(intrCount),  32'(nIn));
        for (int i = 0; i < got.size(); i++) begin
            checkOutput($sformatf("pixel r%0d c%0d", i / W, i % W),
                        32'(got[i]), 32'(modelPixel(i / W, i % W)));
        end
        if (readyMode == 3) begin
            checkOutput("ready low while 4 rows full", 32'(sawReadyInFull), 0);
            checkOutput("full phase reached",          32'(fullCycles > 0), 1);
        end
    endtask

    initial begin
        rst          = 1'b0;
        i_valid      = 1'b0;
        i_data       = 8'h00;
        i_data_ready = 1'b1;

        $display("[TB] reset, then abandon a partial row");
        doReset();
        repeat (700) begin
            @(posedge clk);
            #1;
            i_valid = ($urandom_range(0, 3) != 0);
            i_data  = 8'($urandom_range(0, 255));
        end

        $display("[TB] random frame, random valid and ready");
        doReset();
        fillFrame(0, 4, 0);
        applyStimulus(4, 2, 1'b1);

        $display("[TB] ramp frame, ready toggling every cycle");
        doReset();
        fillFrame(2, 3, 0);
        applyStimulus(3, 1, 1'b0);
        checkOutput("ramp col 0", 32'(gotAt(0)), 1);
        checkOutput("ramp col 5", 32'(gotAt(5)), 6);

`ifdef KERNEL_GAUSSIAN_EN
        $display("[TB] constant 160 frame");
        doReset();
        fillFrame(1, 3, 160);
        applyStimulus(3, 0, 1'b0);
        checkOutput("const interior", 32'(gotAt(256)), 160);
`else
        $display("[TB] constant 100 frame");
        doReset();
        fillFrame(1, 3, 100);
        applyStimulus(3, 0, 1'b0);
        checkOutput("const interior",   32'(gotAt(256)),       100);
        checkOutput("const col 510",    32'(gotAt(510)),       66);
        checkOutput("const col 511",    32'(gotAt(511)),       33);
        checkOutput("const row H-2",    32'(gotAt(W + 256)),   66);
        checkOutput("const row H-1",    32'(gotAt(2*W + 256)), 33);
        checkOutput("const corner",     32'(gotAt(2*W + 511)), 11);
`endif

        $display("[TB] four rows without waiting, sink stalled");
        doReset();
        fillFrame(0, 4, 0);
        applyStimulus(4, 3, 1'b0);

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule
